// File: rtl/execute_stage_mc_if.sv
// Handshake bundle between decode/forwarding and the multi-cycle execute stage.
// The execute stage takes the slave side; the producer/consumer pair takes master.
interface execute_stage_mc_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             stall;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       flags;
  logic             flag_update;
  logic             busy;

  modport slave (
    input  flush, stall, in_valid, src1, src2, alu_op,
    output in_ready, out_valid, alu_result, flags, flag_update, busy
  );

  modport master (
    output flush, stall, in_valid, src1, src2, alu_op,
    input  in_ready, out_valid, alu_result, flags, flag_update, busy
  );
endinterface

// File: rtl/execute_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU ops plus an iterative shift-add
// multiplier, with a held result/NZV register that respects downstream stall.
module execute_stage_mc #(
  parameter int WIDTH          = 16,
  parameter int MUL_RADIX_BITS = 1
) (
  input logic               clk,
  input logic               rst_n,
  execute_stage_mc_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int N       = WIDTH / MUL_RADIX_BITS;
  localparam int CNT_W   = $clog2(N);
  localparam int LANES   = WIDTH / 4;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h9;
  localparam logic [3:0] OP_ADDNF  = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_LHB    = 4'hC;
  localparam logic [3:0] OP_PASS   = 4'hD;
  localparam logic [3:0] OP_MUL    = 4'hE;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg;
  logic             busy_reg;
  logic             out_valid_reg;
  logic             flag_op_reg;
  logic [WIDTH-1:0] result_reg;
  logic [2:0]       flags_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;

  logic             out_hold;
  logic             accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sat_diff;
  logic [WIDTH-1:0] paddsb;
  logic [WIDTH-1:0] alu_next;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] pp_terms [MUL_RADIX_BITS];
  logic             add_v;
  logic             sub_v;
  logic             v_next;
  logic             upd_nzv;
  logic             upd_z;
  logic [2:0]       flags_next;

  assign out_hold        = out_valid_reg & bus.stall;
  assign bus.in_ready    = ~bus.flush & ~busy_reg & ~out_hold;
  assign accept          = bus.in_valid & bus.in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.alu_result  = result_reg;
  assign bus.flags       = flags_reg;
  assign bus.flag_update = out_valid_reg & flag_op_reg;
  assign bus.busy        = busy_reg;

  // Nibble lanes add independently; carries out of each lane are discarded.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_paddsb
    assign paddsb[4*gi +: 4] = bus.src1[4*gi +: 4] + bus.src2[4*gi +: 4];
  end

  for (gi = 0; gi < MUL_RADIX_BITS; gi++) begin : g_pp
    assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
  end

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_RADIX_BITS; i++) begin
      partial = partial + pp_terms[i];
    end
    mul_sum = acc_reg + partial;
  end

  always_comb begin
    shamt    = bus.src2[SHAMT_W-1:0];
    sum      = bus.src1 + bus.src2;
    diff     = bus.src1 - bus.src2;
    add_v    = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (sum[WIDTH-1] != bus.src1[WIDTH-1]);
    sub_v    = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (diff[WIDTH-1] != bus.src1[WIDTH-1]);
    // On overflow the sign of src1 picks the rail: negative -> 0x80..0, positive -> 0x7F..F.
    sat_diff = sub_v ? {bus.src1[WIDTH-1], {(WIDTH-1){~bus.src1[WIDTH-1]}}} : diff;
    alu_next = '0;
    v_next   = 1'b0;
    upd_nzv  = 1'b0;
    upd_z    = 1'b0;
    case (bus.alu_op)
      OP_ADD:    begin alu_next = sum;      v_next = add_v; upd_nzv = 1'b1; end
      OP_SUB:    begin alu_next = sat_diff; v_next = sub_v; upd_nzv = 1'b1; end
      OP_XOR:    begin alu_next = bus.src1 ^ bus.src2;      upd_z = 1'b1; end
      OP_SLL:    begin alu_next = bus.src1 << shamt;        upd_z = 1'b1; end
      OP_SRA:    begin alu_next = $unsigned($signed(bus.src1) >>> shamt); upd_z = 1'b1; end
      OP_ROR:    begin alu_next = WIDTH'({bus.src1, bus.src1} >> shamt); upd_z = 1'b1; end
      OP_PADDSB: alu_next = paddsb;
      OP_ADDNF:  alu_next = sum;
      OP_LLB:    alu_next = {bus.src1[WIDTH-1:8], bus.src2[7:0]};
      OP_LHB:    alu_next = {bus.src2[7:0], bus.src1[WIDTH-9:0]};
      OP_PASS:   alu_next = bus.src1;
      default:   alu_next = '0;
    endcase
    flags_next = flags_reg;
    if (upd_nzv) begin
      flags_next = {alu_next[WIDTH-1], alu_next == '0, v_next};
    end else if (upd_z) begin
      flags_next[1] = (alu_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      flag_op_reg   <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      count_reg     <= '0;
    end else if (bus.flush) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      flag_op_reg   <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (out_valid_reg && !bus.stall) begin
        out_valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (accept && bus.alu_op == OP_MUL) begin
            mcand_reg  <= bus.src1;
            mplier_reg <= bus.src2;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= MUL;
          end else if (accept) begin
            result_reg    <= alu_next;
            flags_reg     <= flags_next;
            flag_op_reg   <= upd_nzv | upd_z;
            out_valid_reg <= 1'b1;
          end
        end
        MUL: begin
          // The last partial is only committed together with the result, so a
          // held output simply retries the same final step next cycle.
          if (count_reg == CNT_W'(N - 1)) begin
            if (!out_hold) begin
              result_reg    <= mul_sum;
              flag_op_reg   <= 1'b0;
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b0;
              count_reg     <= '0;
              state_reg     <= IDLE;
            end
          end else begin
            acc_reg    <= mul_sum;
            mcand_reg  <= mcand_reg << MUL_RADIX_BITS;
            mplier_reg <= mplier_reg >> MUL_RADIX_BITS;
            count_reg  <= count_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: directed spec vectors, multiplier
// timing/stall/flush/reset scenarios, and randomized traffic against a reference model.
module tb_execute_stage_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_mc_if #(.WIDTH(16)) bus ();
  execute_stage_mc_if #(.WIDTH(32)) bus32 ();

  execute_stage_mc #(.WIDTH(16), .MUL_RADIX_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  execute_stage_mc #(.WIDTH(32), .MUL_RADIX_BITS(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  f;
    logic        fu;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [2:0] mflags = 3'b000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: arithmetic on plain integers, results follow the opcode table.
  function automatic void model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   inout logic [2:0] fl, output logic [15:0] r, output logic fu);
    int sa, sb, s, amt;
    longint p;
    bit v;
    sa = $signed(a);
    sb = $signed(b);
    amt = int'(b[3:0]);
    r = '0;
    fu = 1'b0;
    v = 1'b0;
    case (op)
      4'h0, 4'hA: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
      4'h1: begin
        s = sa - sb;
        if (s > 32767) begin r = 16'h7FFF; v = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
        else r = s[15:0];
      end
      4'h2: r = a ^ b;
      4'h4: begin s = int'(a) * (1 << amt); r = s[15:0]; end
      4'h5: begin r = a; repeat (amt) r = {r[15], r[15:1]}; end
      4'h6: begin r = a; repeat (amt) r = {r[0], r[15:1]}; end
      4'h9: for (int l = 0; l < 4; l++) r[4*l +: 4] = 4'((int'(a[4*l +: 4]) + int'(b[4*l +: 4])) % 16);
      4'hB: r = {a[15:8], b[7:0]};
      4'hC: r = {b[7:0], a[7:0]};
      4'hD: r = a;
      4'hE: begin p = longint'(a) * longint'(b); r = p[15:0]; end
      default: r = '0;
    endcase
    if (op == 4'h0 || op == 4'h1) begin
      fl = {r[15], r == 16'h0, v};
      fu = 1'b1;
    end else if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) begin
      fl[1] = (r == 16'h0);
      fu = 1'b1;
    end
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op = op;
    bus.src1 = a;
    bus.src2 = b;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update, bus.in_ready} !== {1'b0, 16'h0, 3'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b res=%h fl=%b busy=%b fu=%b rdy=%b, expected 0/0000/000/0/0/1",
               bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mflags = 3'b000;
  endtask

  task automatic test_alu_directed();
    logic [3:0]  ops [5] = '{4'h0, 4'h1, 4'h1, 4'h2, 4'hD};
    logic [15:0] av  [5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hABCD};
    logic [15:0] bv  [5] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000};
    logic [15:0] rv  [5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'hABCD};
    logic [2:0]  fv  [5] = '{3'b101, 3'b101, 3'b001, 3'b011, 3'b011};
    logic        fuv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic rdy;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], av[i], bv[i]);
      rdy = bus.in_ready;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({rdy, bus.out_valid, bus.alu_result, bus.flags, bus.flag_update} !== {1'b1, 1'b1, rv[i], fv[i], fuv[i]}) begin
        errors++;
        $display("FAIL alu_directed[%0d] op=%h: got rdy=%b ov=%b res=%h fl=%b fu=%b, expected 1/1/%h/%b/%b",
                 i, ops[i], rdy, bus.out_valid, bus.alu_result, bus.flags, bus.flag_update, rv[i], fv[i], fuv[i]);
      end
    end
    tick();
    mflags = 3'b011;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_consume: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_mul();
    drive(4'hE, 16'h0123, 16'h0010);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_accept_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    // Keep a competing op presented: it must not be taken while busy.
    drive(4'hD, 16'hFFFF, 16'h0000);
    for (int e = 1; e <= 16; e++) begin
      checks++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b010) begin
        errors++;
        $display("FAIL mul_busy edge %0d: got ov=%b busy=%b rdy=%b, expected 0/1/0", e - 1, bus.out_valid, bus.busy, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update} !== {1'b1, 16'h1230, mflags, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_result: got ov=%b res=%h fl=%b busy=%b fu=%b, expected 1/1230/%b/0/0",
               bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update, mflags);
    end
    tick();
  endtask

  task automatic test_mul_stall();
    drive(4'hE, 16'h0123, 16'h0010);
    tick();
    bus.in_valid = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 15) bus.stall = 1'b1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.out_valid, bus.alu_result, bus.busy, bus.in_ready} !== {1'b1, 16'h1230, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mul_stall_hold[%0d]: got ov=%b res=%h busy=%b rdy=%b, expected 1/1230/0/0",
                 k, bus.out_valid, bus.alu_result, bus.busy, bus.in_ready);
      end
      if (k < 3) tick();
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_stall_release: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    logic [15:0] r;
    logic fu;
    drive(4'hE, 16'hFFFF, 16'h0003);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.flush = 1'b1;
    drive(4'h0, 16'h0001, 16'h0001);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.flags} !== {1'b0, 1'b0, 1'b1, mflags}) begin
      errors++;
      $display("FAIL flush_state: got ov=%b busy=%b rdy=%b fl=%b, expected 0/0/1/%b",
               bus.out_valid, bus.busy, bus.in_ready, bus.flags, mflags);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_result: got out_valid=1 after flush, expected 0");
    end
    drive(4'h0, 16'h0002, 16'h0003);
    tick();
    bus.in_valid = 1'b0;
    model_op(4'h0, 16'h0002, 16'h0003, mflags, r, fu);
    checks++;
    if ({bus.out_valid, bus.alu_result, bus.flags} !== {1'b1, r, mflags}) begin
      errors++;
      $display("FAIL flush_recover: got ov=%b res=%h fl=%b, expected 1/%h/%b", bus.out_valid, bus.alu_result, bus.flags, r, mflags);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [15:0] a, b, r;
    logic fu, rdy;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hE) op = 4'h1;
      a = 16'($urandom);
      b = 16'($urandom);
      drive(op, a, b);
      rdy = bus.in_ready;
      model_op(op, a, b, mflags, r, fu);
      tick();
      checks++;
      if ({rdy, bus.out_valid, bus.alu_result, bus.flags, bus.flag_update} !== {1'b1, 1'b1, r, mflags, fu}) begin
        errors++;
        $display("FAIL back_to_back[%0d] op=%h a=%h b=%h: got rdy=%b ov=%b res=%h fl=%b fu=%b, expected 1/1/%h/%b/%b",
                 i, op, a, b, rdy, bus.out_valid, bus.alu_result, bus.flags, bus.flag_update, r, mflags, fu);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit have = 1'b0;
    logic [3:0] op;
    logic [15:0] a, b;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        op = 4'($urandom_range(0, 15));
        a = 16'($urandom);
        b = 16'($urandom);
        have = 1'b1;
      end
      bus.in_valid = have;
      bus.alu_op = op;
      bus.src1 = a;
      bus.src2 = b;
      bus.stall = ($urandom_range(0, 3) == 0);
      #1;
      if (bus.out_valid && !bus.stall) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_unexpected: got result %h with nothing outstanding", bus.alu_result);
        end else begin
          e = q.pop_front();
          if ({bus.alu_result, bus.flags, bus.flag_update} !== {e.r, e.f, e.fu}) begin
            errors++;
            $display("FAIL random_result cyc %0d: got res=%h fl=%b fu=%b, expected %h/%b/%b",
                     cyc, bus.alu_result, bus.flags, bus.flag_update, e.r, e.f, e.fu);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model_op(op, a, b, mflags, e.r, e.fu);
        e.f = mflags;
        q.push_back(e);
        have = 1'b0;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      if (bus.out_valid) begin
        e = q.pop_front();
        checks++;
        if ({bus.alu_result, bus.flags, bus.flag_update} !== {e.r, e.f, e.fu}) begin
          errors++;
          $display("FAIL random_drain: got res=%h fl=%b fu=%b, expected %h/%b/%b",
                   bus.alu_result, bus.flags, bus.flag_update, e.r, e.f, e.fu);
        end
      end
      tick();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL random_timeout: got %0d results outstanding, expected 0", q.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(4'hE, 16'h0123, 16'h0010);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid_mul: got ov=%b res=%h fl=%b busy=%b fu=%b, expected all 0",
               bus.out_valid, bus.alu_result, bus.flags, bus.busy, bus.flag_update);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mflags = 3'b000;
    tick();
  endtask

  task automatic test_wide();
    bus32.in_valid = 1'b1;
    bus32.alu_op = 4'hE;
    bus32.src1 = 32'h0001_0000;
    bus32.src2 = 32'h0001_0000;
    #1;
    tick();
    bus32.in_valid = 1'b0;
    repeat (15) tick();
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wide_mul_early: got out_valid=%b after 15 edges, expected 0", bus32.out_valid);
    end
    tick();
    checks++;
    if ({bus32.out_valid, bus32.alu_result, bus32.busy} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wide_mul: got ov=%b res=%h busy=%b, expected 1/00000000/0", bus32.out_valid, bus32.alu_result, bus32.busy);
    end
    bus32.in_valid = 1'b1;
    bus32.alu_op = 4'h6;
    bus32.src1 = 32'h0000_0001;
    bus32.src2 = 32'h0000_0001;
    #1;
    tick();
    bus32.in_valid = 1'b0;
    checks++;
    if ({bus32.out_valid, bus32.alu_result, bus32.flags, bus32.flag_update} !== {1'b1, 32'h8000_0000, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL wide_ror: got ov=%b res=%h fl=%b fu=%b, expected 1/80000000/000/1",
               bus32.out_valid, bus32.alu_result, bus32.flags, bus32.flag_update);
    end
    tick();
  endtask

  initial begin
    bus.flush = 1'b0;    bus.stall = 1'b0;    bus.in_valid = 1'b0;
    bus.alu_op = 4'h0;   bus.src1 = '0;       bus.src2 = '0;
    bus32.flush = 1'b0;  bus32.stall = 1'b0;  bus32.in_valid = 1'b0;
    bus32.alu_op = 4'h0; bus32.src1 = '0;     bus32.src2 = '0;
    test_reset();
    test_alu_directed();
    test_mul();
    test_mul_stall();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
